// File: rtl/uart_tx_engine_if.sv
// ---------------------------------------------------------------------------
// uart_tx_engine_if
// Handshake and line bundle between the transmit holding register (master)
// and the UART transmit engine (slave).
//   START  : transmit request (valid), master -> engine
//   DATA   : frame payload, sampled when START && READY
//   BREAK  : level abort request
//   READY  : engine idle, START may be accepted
//   BUSY   : frame in progress (always !READY)
//   DONE   : one-cycle pulse when the last stop bit completes
//   TXD    : serial line, idles high
//   STATE  : engine state code for debug/status
// ---------------------------------------------------------------------------
interface uart_tx_engine_if #(
    parameter int DATA_BITS = 8
);
    logic                 START;
    logic [DATA_BITS-1:0] DATA;
    logic                 BREAK;
    logic                 READY;
    logic                 BUSY;
    logic                 DONE;
    logic                 TXD;
    logic [2:0]           STATE;

    modport master (
        output START, DATA, BREAK,
        input  READY, BUSY, DONE, TXD, STATE
    );

    modport slave (
        input  START, DATA, BREAK,
        output READY, BUSY, DONE, TXD, STATE
    );
endinterface

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// Bit-level UART transmit frame sequencer: start bit, DATA_BITS data bits
// LSB first, optional parity bit, STOP_BITS stop bits. Every bit lasts one
// period of the external baud tick BCLK.
//   CLK    : system clock
//   RESET  : asynchronous, active-low reset
//   BCLK   : one-CLK-wide baud tick, once per bit period
//   tx     : slave side of uart_tx_engine_if (START/DATA/BREAK in,
//            READY/BUSY/DONE/TXD/STATE out, all outputs registered)
// ---------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BCLK,
    uart_tx_engine_if.slave  tx
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_STRT = 3'd2,
        ST_DATA = 3'd3,
        ST_PAR  = 3'd4,
        ST_STOP = 3'd5
    } state_t;

    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic [1:0] LAST_STOP  = 2'(STOP_BITS - 1);
    localparam logic       PAR_SENSE  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic       PAR_ENABLE = (PARITY_EN != 0) ? 1'b1 : 1'b0;

    state_t               state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [3:0]           bit_cnt_r;
    logic [1:0]           stop_cnt_r;
    logic                 parity_r;
    logic                 txd_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;

    // Fold one transmitted data bit into the running parity accumulator.
    function automatic logic par_step(input logic acc, input logic data_bit);
        return acc ^ data_bit;
    endfunction

    // Line value of the parity bit for a given accumulator.
    function automatic logic par_line(input logic acc);
        return acc ^ PAR_SENSE;
    endfunction

    // Frame sequencer: state, shift register, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 2'd0;
            parity_r   <= 1'b0;
            txd_r      <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (tx.BREAK && (state_r != ST_IDLE)) begin
                // Abort wins over any baud tick; no DONE for a broken frame.
                state_r    <= ST_IDLE;
                bit_cnt_r  <= 4'd0;
                stop_cnt_r <= 2'd0;
                txd_r      <= 1'b1;
                ready_r    <= 1'b1;
                busy_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        txd_r   <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        // BCLK is deliberately ignored here: a tick coinciding
                        // with acceptance is not consumed, SYNC waits for the
                        // next one so the start bit is a full period.
                        if (tx.START && !tx.BREAK) begin
                            state_r    <= ST_SYNC;
                            shift_r    <= tx.DATA;
                            bit_cnt_r  <= 4'd0;
                            stop_cnt_r <= 2'd0;
                            parity_r   <= 1'b0;
                            ready_r    <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_SYNC: begin
                        if (BCLK) begin
                            state_r <= ST_STRT;
                            txd_r   <= 1'b0;
                        end else begin
                            txd_r <= 1'b1;
                        end
                    end
                    ST_STRT: begin
                        if (BCLK) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 4'd0;
                            txd_r     <= shift_r[0];
                        end else begin
                            txd_r <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (BCLK) begin
                            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                            parity_r  <= par_step(parity_r, shift_r[0]);
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                if (PAR_ENABLE) begin
                                    state_r <= ST_PAR;
                                    // Parity must include the bit leaving now.
                                    txd_r   <= par_line(par_step(parity_r, shift_r[0]));
                                end else begin
                                    state_r    <= ST_STOP;
                                    stop_cnt_r <= 2'd0;
                                    txd_r      <= 1'b1;
                                end
                            end else begin
                                // Next data bit is the one about to become bit 0.
                                txd_r <= shift_r[1];
                            end
                        end else begin
                            txd_r <= shift_r[0];
                        end
                    end
                    ST_PAR: begin
                        if (BCLK) begin
                            state_r    <= ST_STOP;
                            stop_cnt_r <= 2'd0;
                            txd_r      <= 1'b1;
                        end else begin
                            txd_r <= par_line(parity_r);
                        end
                    end
                    ST_STOP: begin
                        txd_r <= 1'b1;
                        if (BCLK) begin
                            if (stop_cnt_r == LAST_STOP) begin
                                state_r    <= ST_IDLE;
                                stop_cnt_r <= 2'd0;
                                ready_r    <= 1'b1;
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                            end else begin
                                stop_cnt_r <= stop_cnt_r + 2'd1;
                            end
                        end else begin
                            stop_cnt_r <= stop_cnt_r;
                        end
                    end
                    default: begin
                        // Codes 6 and 7 are unreachable; recover to a safe idle line.
                        state_r    <= ST_IDLE;
                        bit_cnt_r  <= 4'd0;
                        stop_cnt_r <= 2'd0;
                        txd_r      <= 1'b1;
                        ready_r    <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx.TXD   = txd_r;
    assign tx.READY = ready_r;
    assign tx.BUSY  = busy_r;
    assign tx.DONE  = done_r;
    assign tx.STATE = state_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Self-checking bench for uart_tx_engine. Four engine instances cover the
// parameter sets needed (8N1, 8E1, 8O1, 5N2); a selector routes the shared
// stimulus to one instance and muxes its outputs back for checking.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

    logic       CLK;
    logic       RESET;
    logic       BCLK;
    logic       start_s;
    logic       break_s;
    logic [8:0] data_s;
    int         sel;
    int         cyc;

    logic       txd_m, ready_m, busy_m, done_m;
    logic [2:0] state_m;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_engine_if #(.DATA_BITS(8)) if0 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if1 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if2 ();
    uart_tx_engine_if #(.DATA_BITS(5)) if3 ();

    assign if0.START = start_s && (sel == 0);
    assign if1.START = start_s && (sel == 1);
    assign if2.START = start_s && (sel == 2);
    assign if3.START = start_s && (sel == 3);
    assign if0.BREAK = break_s && (sel == 0);
    assign if1.BREAK = break_s && (sel == 1);
    assign if2.BREAK = break_s && (sel == 2);
    assign if3.BREAK = break_s && (sel == 3);
    assign if0.DATA  = data_s[7:0];
    assign if1.DATA  = data_s[7:0];
    assign if2.DATA  = data_s[7:0];
    assign if3.DATA  = data_s[4:0];

    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_8n1 (.CLK(CLK), .RESET(RESET), .BCLK(BCLK), .tx(if0));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_8e1 (.CLK(CLK), .RESET(RESET), .BCLK(BCLK), .tx(if1));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        u_8o1 (.CLK(CLK), .RESET(RESET), .BCLK(BCLK), .tx(if2));
    uart_tx_engine #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u_5n2 (.CLK(CLK), .RESET(RESET), .BCLK(BCLK), .tx(if3));

    always_comb begin
        case (sel)
            1: begin txd_m = if1.TXD; ready_m = if1.READY; busy_m = if1.BUSY; done_m = if1.DONE; state_m = if1.STATE; end
            2: begin txd_m = if2.TXD; ready_m = if2.READY; busy_m = if2.BUSY; done_m = if2.DONE; state_m = if2.STATE; end
            3: begin txd_m = if3.TXD; ready_m = if3.READY; busy_m = if3.BUSY; done_m = if3.DONE; state_m = if3.STATE; end
            default: begin txd_m = if0.TXD; ready_m = if0.READY; busy_m = if0.BUSY; done_m = if0.DONE; state_m = if0.STATE; end
        endcase
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Baud tick: one CLK wide, every 16 CLK, changed on the falling edge.
    initial begin
        cyc  = 0;
        BCLK = 1'b0;
        forever begin
            @(negedge CLK);
            cyc  = cyc + 1;
            BCLK = ((cyc % 16) == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          sel;
        logic [8:0]  data;
        int          nbits;  // frame bits from start bit through the last stop bit
        logic [15:0] exp;    // exp[i] = TXD during bit i of the frame
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge, when BCLK is already settled.
    task automatic step_in();
        @(negedge CLK);
        #1;
    endtask

    // Present one START cycle and check the acceptance edge.
    task automatic start_frame(input string tag, input logic [8:0] d);
        step_in();
        start_s = 1'b1;
        data_s  = d;
        @(posedge CLK);
        #1;
        chk({tag, ".acc_ready"}, 32'(ready_m), 32'd0);
        chk({tag, ".acc_state"}, 32'(state_m), 32'd1);
        step_in();
        start_s = 1'b0;
    endtask

    // Wait (bounded) for the selected engine to be idle again.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (ready_m !== 1'b1 && n < 600) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (ready_m !== 1'b1) chk({tag, ".drain_timeout"}, 32'(ready_m), 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [15:0] frame;
        logic [15:0] mask;
        int ticks, cycles, sync_cyc, done_tick, dones;
        logic bt;
        sel = v.sel;
        start_frame(tag, v.data);
        frame = 16'd0;
        mask  = 16'((32'd1 << v.nbits) - 32'd1);
        ticks = 0; cycles = 0; sync_cyc = 0; done_tick = 0; dones = 0;
        while (done_tick == 0 && cycles < 400) begin
            @(posedge CLK);
            bt = BCLK;
            #1;
            cycles++;
            if (done_m === 1'b1) dones++;
            if (bt) begin
                ticks++;
                if (ticks == 1) sync_cyc = cycles;
                if (done_m === 1'b1) done_tick = ticks;
                else if (ticks <= 16) frame[ticks-1] = txd_m;
            end
        end
        chk({tag, ".frame"}, 32'(frame & mask), 32'(v.exp));
        chk({tag, ".done_tick"}, 32'(done_tick), 32'(v.nbits + 1));
        chk({tag, ".done_cycles"}, 32'(cycles - sync_cyc), 32'(16 * v.nbits));
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (done_m === 1'b1) dones++;
        end
        chk({tag, ".done_count"}, 32'(dones), 32'd1);
        chk({tag, ".idle_ready"}, 32'(ready_m), 32'd1);
        chk({tag, ".idle_busy"}, 32'(busy_m), 32'd0);
        chk({tag, ".idle_state"}, 32'(state_m), 32'd0);
        chk({tag, ".idle_txd"}, 32'(txd_m), 32'd1);
    endtask

    initial begin : main
        int   n, ticks, accepts, dones, after_done_state;
        logic prev_ready, prev_done, bt;

        RESET   = 1'b0;
        start_s = 1'b0;
        break_s = 1'b0;
        data_s  = 9'd0;
        sel     = 0;

        // Hand-computed frames, start bit first, LSB-first data.
        vecs[0] = '{0, 9'h055, 10, 16'h02AA}; // 0,1,0,1,0,1,0,1,0,1
        vecs[1] = '{1, 9'h007, 11, 16'h060E}; // even parity of 0x07 -> 1
        vecs[2] = '{2, 9'h007, 11, 16'h040E}; // odd parity of 0x07 -> 0
        vecs[3] = '{3, 9'h01F,  8, 16'h00FE}; // 0,1,1,1,1,1,1,1
        vecs[4] = '{0, 9'h0A5, 10, 16'h034A}; // 0,1,0,1,0,0,1,0,1,1
        vecs[5] = '{0, 9'h03C, 10, 16'h0278}; // 0,0,0,1,1,1,1,0,0,1
        vecs[6] = '{1, 9'h0FF, 11, 16'h05FE}; // even parity of 0xFF -> 0
        vecs[7] = '{3, 9'h00A,  8, 16'h00D4}; // 0,0,1,0,1,0,1,1

        // Reset values on every instance.
        repeat (3) @(posedge CLK);
        #1;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d.txd", s), 32'(txd_m), 32'd1);
            chk($sformatf("rst%0d.ready", s), 32'(ready_m), 32'd1);
            chk($sformatf("rst%0d.busy", s), 32'(busy_m), 32'd0);
            chk($sformatf("rst%0d.done", s), 32'(done_m), 32'd0);
            chk($sformatf("rst%0d.state", s), 32'(state_m), 32'd0);
        end
        sel = 0;
        step_in();
        RESET = 1'b1;
        repeat (3) step_in();

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // START coinciding with BCLK: accepted, tick not consumed.
        sel = 0;
        n = 0;
        step_in();
        while (BCLK !== 1'b1 && n < 40) begin step_in(); n++; end
        start_s = 1'b1;
        data_s  = 9'h055;
        @(posedge CLK);
        #1;
        chk("cotick.state_sync", 32'(state_m), 32'd1);
        step_in();
        start_s = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("cotick.still_sync", 32'(state_m), 32'd1);
        n = 0;
        bt = 1'b0;
        while (!bt && n < 40) begin @(posedge CLK); bt = BCLK; n++; end
        #1;
        chk("cotick.strt", 32'(state_m), 32'd2);
        chk("cotick.start_bit", 32'(txd_m), 32'd0);
        drain("cotick");

        // BREAK in IDLE blocks START.
        step_in();
        break_s = 1'b1;
        start_s = 1'b1;
        data_s  = 9'h0A5;
        @(posedge CLK);
        #1;
        chk("brkidle.state", 32'(state_m), 32'd0);
        chk("brkidle.ready", 32'(ready_m), 32'd1);
        step_in();
        break_s = 1'b0;
        start_s = 1'b0;

        // BREAK during data bit 3 of 0xA5 (bit 3 is 0 on the line).
        start_frame("brk", 9'h0A5);
        ticks = 0;
        n = 0;
        while (ticks < 5 && n < 200) begin
            @(posedge CLK);
            if (BCLK) ticks++;
            n++;
        end
        repeat (4) @(posedge CLK);
        #1;
        chk("brk.in_data", 32'(state_m), 32'd3);
        chk("brk.bit3", 32'(txd_m), 32'd0);
        step_in();
        break_s = 1'b1;
        @(posedge CLK);
        #1;
        chk("brk.txd", 32'(txd_m), 32'd1);
        chk("brk.state", 32'(state_m), 32'd0);
        chk("brk.ready", 32'(ready_m), 32'd1);
        chk("brk.done", 32'(done_m), 32'd0);
        step_in();
        break_s = 1'b0;
        dones = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge CLK);
            #1;
            if (done_m === 1'b1) dones++;
        end
        chk("brk.no_done", 32'(dones), 32'd0);
        run_vec("brk_after", vecs[4]);

        // Back-to-back: START held high through DONE with 0x3C.
        sel = 0;
        step_in();
        start_s = 1'b1;
        data_s  = 9'h03C;
        prev_ready = ready_m;
        prev_done  = 1'b0;
        accepts = 0;
        dones   = 0;
        after_done_state = -1;
        n = 0;
        while (dones < 2 && n < 800) begin
            @(posedge CLK);
            #1;
            n++;
            if (prev_ready && state_m == 3'd1) accepts++;
            if (prev_done && dones == 1 && after_done_state < 0) after_done_state = int'(state_m);
            if (done_m === 1'b1) dones++;
            if (accepts == 2) start_s = 1'b0;
            prev_ready = ready_m;
            prev_done  = done_m;
        end
        start_s = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (prev_ready && state_m == 3'd1) accepts++;
            if (done_m === 1'b1) dones++;
            prev_ready = ready_m;
        end
        chk("b2b.accepts", 32'(accepts), 32'd2);
        chk("b2b.dones", 32'(dones), 32'd2);
        chk("b2b.sync_after_done", 32'(after_done_state), 32'd1);

        // RESET asserted while in STOP: outputs return without a clock edge.
        start_frame("rst", 9'h000);
        n = 0;
        while (state_m != 3'd5 && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("rst.reached_stop", 32'(state_m), 32'd5);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("rst.async_txd", 32'(txd_m), 32'd1);
        chk("rst.async_ready", 32'(ready_m), 32'd1);
        chk("rst.async_state", 32'(state_m), 32'd0);
        chk("rst.async_busy", 32'(busy_m), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK);
            #1;
            if (done_m === 1'b1) dones++;
        end
        chk("rst.no_done", 32'(dones), 32'd0);
        chk("rst.stays_idle", 32'(state_m), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine. Replaces the two-state IDLE/BUSY transmit controller with a full bit-level frame sequencer: start bit, 5–9 data bits LSB first, optional parity, and 1 or 2 stop bits. Paced by an external one-cycle baud tick from the UART baud generator. Sits between the transmit holding register (valid/ready handshake) and the TXD pin.

Parameters:
DATA_BITS, 8, number of data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous, active-low reset.
BCLK  input  1  baud tick; one CLK cycle wide, once per bit period.
START  input  1  transmit request (valid).
DATA  input  DATA_BITS  frame payload; sampled when START && READY.
BREAK  input  1  abort request; synchronous, level.
READY  output  1  engine idle; can accept START.
TXD  output  1  serial line; idles high.
BUSY  output  1  frame in progress; equals !READY.
DONE  output  1  one-cycle pulse when the last stop bit completes.
STATE  output  3  current state code, for debug and status.

Behaviour:
- Reset values: state IDLE, TXD=1, READY=1, BUSY=0, DONE=0, shift register 0, all counters 0. All outputs are registered.
- State codes: IDLE=0, SYNC=1, STRT=2, DATA=3, PAR=4, STOP=5. Codes 6 and 7 are illegal; both go to IDLE on the next CLK with TXD=1.
- IDLE:
  - TXD=1, READY=1.
  - START high latches DATA into the shift register and moves to SYNC on the same edge.
  - READY drops to 0 the following cycle.
  - START is ignored while READY=0.
- SYNC:
  - TXD=1; waits for BCLK so every bit lasts exactly one baud period.
  - On BCLK, moves to STRT.
- STRT:
  - TXD=0 for one baud period.
  - On BCLK, moves to DATA with bit counter=0.
- DATA:
  - TXD = shift register bit 0.
  - On each BCLK, shift right and increment the counter.
  - After DATA_BITS ticks, moves to PAR if PARITY_EN=1, otherwise to STOP.
  - Parity accumulator = XOR of the transmitted data bits, computed during shifting.
- PAR:
  - TXD = accumulator XOR PARITY_ODD.
  - On BCLK, moves to STOP.
- STOP:
  - TXD=1; stop counter counts BCLK ticks.
  - After STOP_BITS ticks, moves to IDLE and pulses DONE for exactly one CLK.
  - READY=1 from the same edge.
- BCLK is only examined in SYNC through STOP. Ticks in IDLE have no effect.
- Simultaneous START and BCLK in IDLE: START is accepted; the tick is not consumed, and SYNC waits for the next tick.
- BREAK:
  - Priority over BCLK in every non-IDLE state.
  - Next CLK: state=IDLE, TXD=1, READY=1, no DONE pulse.
  - BREAK in IDLE blocks START acceptance while high.
- Back-to-back frames: START held high with new DATA in the DONE cycle is accepted. The next frame's SYNC waits for a fresh tick, so there is no gap beyond the bit alignment.
- RESET asserted mid-frame: immediate return to reset values. TXD goes high asynchronously.
- Frame length in baud ticks, excluding SYNC: 1 + DATA_BITS + PARITY_EN + STOP_BITS.

Test Plan:
1. Defaults, DATA=0x55, START pulse, BCLK every 16 CLK -> TXD per tick: 0,1,0,1,0,1,0,1,0,1. DONE pulses once 160 CLK after the SYNC tick. READY=1 afterwards.
2. PARITY_EN=1, PARITY_ODD=0, DATA=0x07 -> parity bit 1. Repeat with PARITY_ODD=1 -> parity bit 0. Frame = 11 ticks.
3. DATA_BITS=5, STOP_BITS=2, DATA=0x1F -> TXD 0,1,1,1,1,1,1,1. Total 8 ticks. DONE only after the second stop tick.
4. BREAK asserted during data bit 3 of 0xA5 -> next CLK: TXD=1, STATE=0, READY=1, DONE stays 0. A new START then sends a complete frame.
5. START held high through DONE with DATA=0x3C -> second frame starts SYNC immediately. Exactly two DONE pulses. No START accepted while BUSY.
6. RESET low during the STOP state -> TXD=1, READY=1, STATE=0 asynchronously. No DONE pulse after release.
